imem_boot_loader: RTL and testbench

- Boot sequencer for the single-cycle core. It holds the core in reset and receives a byte-serial program image over a valid/ready stream.
- It writes the image word-by-word into the instruction memory write port, then verifies a checksum.
- On success it releases the core reset. It sits between the host/debug link and the DataPath top, replacing testbench hierarchical preloading of instruction memory.

---
 rtl/imem_boot_loader_pkg.sv | 25 ++
 rtl/imem_boot_loader_word_pack.sv | 32 +++
 rtl/imem_boot_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and image-format constants for the instruction memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RUN,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } load_err_t;

    // The image header carries the word count, little-endian.
    localparam int HDR_BYTES = 2;
    localparam int LEN_W     = 8 * HDR_BYTES;

endpackage

// File: rtl/imem_boot_loader_word_pack.sv
// Assembles four little-endian bytes into one 32-bit word; word_valid marks the fourth byte.
module loader_word_pack (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    // Shift earlier bytes down so byte 0 ends up in the least significant position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (byte_valid) begin
            byte_idx  <= byte_idx + 2'd1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_idx == 2'd3);
    assign word       = {byte_data, low_bytes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a length-prefixed, XOR-checksummed image over a byte stream,
// writes it into instruction memory and releases the core reset once it verifies.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 256,
    parameter int unsigned ADDR_W         = $clog2(IMEM_DEPTH),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              load_done,
    output logic [1:0]        load_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t    state, state_next;
    load_err_t        err_q, err_next;
    logic [7:0]       chk, chk_next;
    logic [7:0]       len_lo, len_lo_next;
    logic [LEN_W-1:0] len, len_next;
    logic [LEN_W-1:0] len_rx;
    logic [LEN_W-1:0] word_cnt, word_cnt_next;
    logic [TO_W-1:0]  idle_cnt, idle_cnt_next;

    logic        loading;
    logic        accept;
    logic        pack_clear;
    logic        pack_valid;
    logic        word_valid;
    logic [31:0] word;

    assign loading    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
    assign accept     = rx_valid && rx_ready;
    assign pack_valid = accept && (state == DATA);
    assign len_rx     = {rx_data, len_lo};

    loader_word_pack u_word_pack (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state, checksum, word counter and idle-timeout logic.
    always_comb begin
        state_next    = state;
        err_next      = err_q;
        chk_next      = chk;
        len_lo_next   = len_lo;
        len_next      = len;
        word_cnt_next = word_cnt;
        idle_cnt_next = idle_cnt;
        pack_clear    = 1'b0;

        if (loading) begin
            if (accept) begin
                idle_cnt_next = '0;
            end else begin
                idle_cnt_next = idle_cnt + TO_W'(1);
            end
        end

        case (state)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_next    = LEN_LO;
                    err_next      = ERR_NONE;
                    chk_next      = 8'd0;
                    len_next      = '0;
                    word_cnt_next = '0;
                    idle_cnt_next = '0;
                    pack_clear    = 1'b1;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_next = rx_data;
                    chk_next    = chk ^ rx_data;
                    state_next  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    chk_next = chk ^ rx_data;
                    len_next = len_rx;
                    if ((len_rx == '0) || (32'(len_rx) > IMEM_DEPTH)) begin
                        state_next = ERROR;
                        err_next   = ERR_LEN;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_next = chk ^ rx_data;
                    if (word_valid) begin
                        word_cnt_next = word_cnt + LEN_W'(1);
                        if (word_cnt == (len - LEN_W'(1))) begin
                            state_next = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (rx_data == chk) begin
                        state_next = RUN;
                    end else begin
                        state_next = ERROR;
                        err_next   = ERR_CHK;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (loading && !accept && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
            state_next = ERROR;
            err_next   = ERR_TIMEOUT;
        end
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            err_q        <= ERR_NONE;
            chk          <= 8'd0;
            len_lo       <= 8'd0;
            len          <= '0;
            word_cnt     <= '0;
            idle_cnt     <= '0;
            rx_ready     <= 1'b0;
            core_reset_n <= 1'b0;
            load_done    <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
        end else begin
            state        <= state_next;
            err_q        <= err_next;
            chk          <= chk_next;
            len_lo       <= len_lo_next;
            len          <= len_next;
            word_cnt     <= word_cnt_next;
            idle_cnt     <= idle_cnt_next;
            rx_ready     <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                            (state_next == DATA)   || (state_next == CHECK);
            core_reset_n <= (state_next == RUN);
            load_done    <= (state_next == RUN);
            imem_we      <= word_valid;
            if (word_valid) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= word;
            end
        end
    end

    assign load_err = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for the boot loader: stimulus queues expected writes and outcomes,
// a monitor pops and compares them whenever the loader presents a write or a result.
module tb_imem_boot_loader;

    localparam int DEPTH = 256;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        load_done;
    logic [1:0]  load_err;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic       done;
        logic [1:0] err;
    } out_t;

    int tests       = 0;
    int fails       = 0;
    int write_count = 0;

    wr_t        exp_wr[$];
    out_t       exp_out[$];
    logic [7:0] stream[$];

    logic [31:0] prog [6] = '{32'h00500093, 32'h00A00113, 32'h002081B3,
                              32'h00302623, 32'h00C02203, 32'h00000063};

    imem_boot_loader #(
        .IMEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: compares every imem write and every load outcome against the queues.
    initial begin
        wr_t  e;
        out_t o;
        logic fin;
        logic fin_q;
        fin_q = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                write_count++;
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write", imem_addr, imem_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    check_output("imem_addr", 32'(imem_addr), 32'(e.addr));
                    check_output("imem_wdata", imem_wdata, e.data);
                end
            end
            fin = (load_done === 1'b1) || (load_err !== 2'd0);
            if (fin && !fin_q) begin
                if (exp_out.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_outcome: got done %0d err %0d, required none", load_done, load_err);
                end else begin
                    o = exp_out.pop_front();
                    check_output("load_done", 32'(load_done), 32'(o.done));
                    check_output("load_err", 32'(load_err), 32'(o.err));
                    check_output("core_reset_n", 32'(core_reset_n), 32'(o.done));
                end
            end
            fin_q = fin;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Offer one byte after an optional idle gap; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL byte_accept: got rx_ready 0 for 40 cycles, required 1");
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) begin
            apply_stimulus(stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Builds an image of the first n program words and queues the expected writes.
    task automatic build_image(input int n, input bit bad);
        logic [7:0] c;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        c = 8'(n) ^ 8'(n >> 8);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = prog[w][8*k +: 8];
                stream.push_back(b);
                c = c ^ b;
            end
            exp_wr.push_back('{addr: 8'(w), data: prog[w]});
        end
        stream.push_back(bad ? ~c : c);
    endtask

    task automatic wait_outcome(input string name);
        int n;
        n = 0;
        while (!(load_done === 1'b1 || load_err !== 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(load_done === 1'b1 || load_err !== 2'd0)) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: got no outcome in 100 cycles, required outcome", name);
        end
        @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        int wc;
        int cycles;
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_output("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_output("rst_imem_we", 32'(imem_we), 32'd0);
        check_output("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        check_output("rst_load_done", 32'(load_done), 32'd0);
        check_output("rst_load_err", 32'(load_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // One-word image, rx_valid held high.
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        exp_wr.push_back('{addr: 8'h00, data: 32'h00500093});
        exp_out.push_back('{done: 1'b1, err: 2'd0});
        pulse_start();
        send_stream(0);
        wait_outcome("one_word");

        // Bad checksum, then a good reload.
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        exp_wr.push_back('{addr: 8'h00, data: 32'h00500093});
        exp_out.push_back('{done: 1'b0, err: 2'd2});
        pulse_start();
        check_output("start_clears_done", 32'(load_done), 32'd0);
        send_stream(0);
        wait_outcome("bad_chk");
        repeat (3) @(negedge clk);
        check_output("bad_chk_core_held", 32'(core_reset_n), 32'd0);
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        exp_wr.push_back('{addr: 8'h00, data: 32'h00500093});
        exp_out.push_back('{done: 1'b1, err: 2'd0});
        pulse_start();
        check_output("start_clears_err", 32'(load_err), 32'd0);
        send_stream(0);
        wait_outcome("reload");

        // Six-word program with random rx_valid gaps.
        wc = write_count;
        build_image(6, 1'b0);
        exp_out.push_back('{done: 1'b1, err: 2'd0});
        pulse_start();
        send_stream(3);
        wait_outcome("six_words");
        check_output("six_write_count", 32'(write_count - wc), 32'd6);

        // Zero length.
        stream = '{8'h00, 8'h00};
        exp_out.push_back('{done: 1'b0, err: 2'd1});
        pulse_start();
        send_stream(0);
        check_output("len_zero_err", 32'(load_err), 32'd1);

        // Length 257 exceeds the memory.
        wc = write_count;
        stream = '{8'h01, 8'h01};
        exp_out.push_back('{done: 1'b0, err: 2'd1});
        pulse_start();
        send_stream(0);
        check_output("len_257_err", 32'(load_err), 32'd1);
        repeat (5) @(negedge clk);
        check_output("len_257_no_write", 32'(write_count - wc), 32'd0);

        // Timeout: three bytes then idle.
        stream = '{8'h02, 8'h00, 8'h11};
        exp_out.push_back('{done: 1'b0, err: 2'd3});
        pulse_start();
        foreach (stream[i]) apply_stimulus(stream[i], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        cycles = 0;
        while (load_err !== 2'd3 && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check_output("timeout_cycles", 32'(cycles), 32'd16);
        check_output("timeout_err", 32'(load_err), 32'd3);

        // start during DATA must not restart the load.
        exp_wr.push_back('{addr: 8'h00, data: 32'h00500093});
        exp_out.push_back('{done: 1'b1, err: 2'd0});
        pulse_start();
        apply_stimulus(8'h01, 0);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h93, 0);
        apply_stimulus(8'h00, 0);
        pulse_start();
        check_output("start_in_data_ready", 32'(rx_ready), 32'd1);
        apply_stimulus(8'h50, 0);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'hC2, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        wait_outcome("start_ignored");

        // rx_valid in RUN is not accepted.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check_output("run_rx_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        check_output("run_still_done", 32'(load_done), 32'd1);

        // Asynchronous reset after five payload bytes.
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        exp_wr.push_back('{addr: 8'h00, data: 32'h00500093});
        pulse_start();
        foreach (stream[i]) apply_stimulus(stream[i], 0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("areset_rx_ready", 32'(rx_ready), 32'd0);
        check_output("areset_imem_we", 32'(imem_we), 32'd0);
        check_output("areset_imem_addr", 32'(imem_addr), 32'd0);
        check_output("areset_imem_wdata", imem_wdata, 32'd0);
        check_output("areset_core_reset_n", 32'(core_reset_n), 32'd0);
        check_output("areset_load_done", 32'(load_done), 32'd0);
        check_output("areset_load_err", 32'(load_err), 32'd0);
        rx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        check_output("writes_drained", 32'(exp_wr.size()), 32'd0);
        check_output("outcomes_drained", 32'(exp_out.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
